// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port (WE3/A3/WD3) between the ALU
//   writeback path (requester 0) and the load/long-latency unit (requester 1).
//   Round-robin arbitration under contention, one registered write per cycle,
//   writes to x0 are accepted but never reach the register file.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   hold                 global stall: no grant, both ready low
//   req0_* / req1_*      valid/rd/data in, ready out (ready = granted)
//   WE3, A3, WD3         registered register-file write port
//   ra1, ra2             current read addresses
//   fwd1_hit, fwd2_hit   read address matches the in-flight write
//   wait0_cnt, wait1_cnt saturating count of cycles valid but not granted
module rf_wb_arbiter #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             req0_valid,
  input  logic [4:0]       req0_rd,
  input  logic [N-1:0]     req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_rd,
  input  logic [N-1:0]     req1_data,
  output logic             req1_ready,
  output logic             WE3,
  output logic [4:0]       A3,
  output logic [N-1:0]     WD3,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic             fwd1_hit,
  output logic             fwd2_hit,
  output logic [CNT_W-1:0] wait0_cnt,
  output logic [CNT_W-1:0] wait1_cnt
);

  // Index of the most recently granted requester; 1 after reset so that
  // requester 0 wins the first conflict.
  logic last;
  logic gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!hold) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (gnt0) begin
      last <= 1'b0;
    end else if (gnt1) begin
      last <= 1'b1;
    end
  end

  // Output stage: address/data hold when idle, only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (gnt0) begin
      WE3 <= (req0_rd != 5'd0);
      A3  <= req0_rd;
      WD3 <= req0_data;
    end else if (gnt1) begin
      WE3 <= (req1_rd != 5'd0);
      A3  <= req1_rd;
      WD3 <= req1_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  // WE3 is never set for x0, so the explicit raK != 0 term is redundant with
  // the write-enable gating but keeps the bypass rule self-evident.
  assign fwd1_hit = WE3 && (ra1 == A3) && (ra1 != 5'd0);
  assign fwd2_hit = WE3 && (ra2 == A3) && (ra2 != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait0_cnt <= '0;
      wait1_cnt <= '0;
    end else begin
      if (req0_valid && !gnt0 && (wait0_cnt != '1)) wait0_cnt <= wait0_cnt + 1'b1;
      if (req1_valid && !gnt1 && (wait1_cnt != '1)) wait1_cnt <= wait1_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed vectors, register-file writes checked
// by a scoreboard monitor; a second instance with 2-bit counters shares the
// stimulus to exercise counter saturation.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  ra1, ra2;

  logic        req0_ready, req1_ready, WE3, fwd1_hit, fwd2_hit;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [15:0] wait0_cnt, wait1_cnt;

  logic        s_req0_ready, s_req1_ready, s_WE3, s_fwd1_hit, s_fwd2_hit;
  logic [4:0]  s_A3;
  logic [31:0] s_WD3;
  logic [1:0]  s_wait0_cnt, s_wait1_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;
  wr_t q[$];

  always #5 clk = ~clk;

  rf_wb_arbiter #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .WE3(WE3), .A3(A3), .WD3(WD3), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .wait0_cnt(wait0_cnt), .wait1_cnt(wait1_cnt)
  );

  rf_wb_arbiter #(.N(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .WE3(s_WE3), .A3(s_A3), .WD3(s_WD3), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(s_fwd1_hit), .fwd2_hit(s_fwd2_hit),
    .wait0_cnt(s_wait0_cnt), .wait1_cnt(s_wait1_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every register-file write must match the oldest
  // expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && WE3) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got A3=%0d WD3=%0h want no write", A3, WD3);
      end else begin
        e = q.pop_front();
        chk("wb_addr", {59'd0, A3}, {59'd0, e.rd});
        chk("wb_data", {32'd0, WD3}, {32'd0, e.d});
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge, then check the
  // combinational ready outputs and the current WE3 mid-cycle. Expected
  // grants with a nonzero rd are queued for the monitor.
  task automatic step(input logic h,
                      input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                      input logic e0, input logic e1, input logic ewe);
    wr_t w;
    @(posedge clk);
    #1;
    hold = h;
    req0_valid = v0; req0_rd = r0; req0_data = d0;
    req1_valid = v1; req1_rd = r1; req1_data = d1;
    #3;
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
    chk("we3", {63'd0, WE3}, {63'd0, ewe});
    if (e0 && r0 != 5'd0) begin w.rd = r0; w.d = d0; q.push_back(w); end
    if (e1 && r1 != 5'd0) begin w.rd = r1; w.d = d1; q.push_back(w); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t w;
    rst = 1'b1; hold = 1'b0;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hA5A5_A5A5;
    req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
    ra1 = 5'd0; ra2 = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #4;
    chk("rst_we3", {63'd0, WE3}, 64'd0);
    chk("rst_a3", {59'd0, A3}, 64'd0);
    chk("rst_wd3", {32'd0, WD3}, 64'd0);
    chk("rst_wait0", {48'd0, wait0_cnt}, 64'd0);
    chk("rst_wait1", {48'd0, wait1_cnt}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd1);

    // First request after reset release
    @(negedge clk);
    rst = 1'b0;
    w.rd = 5'd5; w.d = 32'hA5A5_A5A5; q.push_back(w);
    #1;
    chk("first_ready0", {63'd0, req0_ready}, 64'd1);

    // x0 write: accepted, never written, no forwarding
    step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, 1, 1);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);
    chk("x0_fwd1", {63'd0, fwd1_hit}, 64'd0);

    // Contention: grants alternate 0,1,0,1 then requester 0 alone
    step(0, 1, 5'd1, 32'h100, 1, 5'd2, 32'h200, 1, 0, 0);
    step(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h200, 0, 1, 1);
    step(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h201, 1, 0, 1);
    step(0, 1, 5'd1, 32'h102, 1, 5'd2, 32'h201, 0, 1, 1);
    step(0, 1, 5'd1, 32'h102, 0, 5'd0, 32'd0,   1, 0, 1);
    step(0, 0, 5'd0, 32'd0,   0, 5'd0, 32'd0,   0, 0, 1);
    chk("cont_wait0", {48'd0, wait0_cnt}, 64'd2);
    chk("cont_wait1", {48'd0, wait1_cnt}, 64'd2);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);

    // Hold for 3 cycles, then grant
    for (int unsigned i = 0; i < 3; i++)
      step(1, 1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0, 0, 0);
    step(0, 1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 1, 0, 0);
    chk("hold_wait0", {48'd0, wait0_cnt}, 64'd5);
    chk("sat_wait0", {62'd0, s_wait0_cnt}, 64'd3);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);

    // Forwarding
    step(0, 1, 5'd9, 32'h20, 0, 5'd0, 32'd0, 1, 0, 0);
    ra1 = 5'd9; ra2 = 5'd3;
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
    chk("fwd1_hit", {63'd0, fwd1_hit}, 64'd1);
    chk("fwd2_hit", {63'd0, fwd2_hit}, 64'd0);
    chk("fwd_wd3", {32'd0, WD3}, 64'h20);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);
    chk("fwd1_idle", {63'd0, fwd1_hit}, 64'd0);
    ra1 = 5'd0; ra2 = 5'd0;

    // Same rd from both: last=0, so requester 1 writes first
    step(0, 1, 5'd4, 32'hAAA, 1, 5'd4, 32'hBBB, 0, 1, 0);
    step(0, 1, 5'd4, 32'hAAA, 0, 5'd0, 32'd0,   1, 0, 1);
    step(0, 0, 5'd0, 32'd0,   0, 5'd0, 32'd0,   0, 0, 1);
    chk("same_wait0", {48'd0, wait0_cnt}, 64'd6);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0);

    // Requester 1 starved by hold for 6 cycles, then granted
    for (int unsigned i = 0; i < 6; i++)
      step(1, 0, 5'd0, 32'd0, 1, 5'd6, 32'h66, 0, 0, 0);
    step(0, 0, 5'd0, 32'd0, 1, 5'd6, 32'h66, 0, 1, 0);
    chk("starve_wait1", {48'd0, wait1_cnt}, 64'd8);
    chk("sat_wait1", {62'd0, s_wait1_cnt}, 64'd3);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 1);
    chk("pre_rst_a3", {59'd0, A3}, 64'd6);
    chk("pre_rst_wd3", {32'd0, WD3}, 64'h66);
    chk("pre_rst_queue", q.size(), 64'd1);
    q.delete();  // this write is discarded by the reset below

    // Asynchronous reset mid-cycle while WE3 is high
    rst = 1'b1;
    #1;
    chk("arst_we3", {63'd0, WE3}, 64'd0);
    chk("arst_a3", {59'd0, A3}, 64'd0);
    chk("arst_wd3", {32'd0, WD3}, 64'd0);
    chk("arst_wait0", {48'd0, wait0_cnt}, 64'd0);
    chk("arst_wait1", {48'd0, wait1_cnt}, 64'd0);
    chk("arst_sat_wait1", {62'd0, s_wait1_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pointer back to reset value: requester 0 wins the first conflict
    step(0, 1, 5'd3, 32'h33, 1, 5'd8, 32'h88, 1, 0, 0);
    step(0, 0, 5'd0, 32'd0,  1, 5'd8, 32'h88, 0, 1, 1);
    step(0, 0, 5'd0, 32'd0,  0, 5'd0, 32'd0,  0, 0, 1);
    step(0, 0, 5'd0, 32'd0,  0, 5'd0, 32'd0,  0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_empty", q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
